// File: rtl/gost89_cfb_ctx_sched.sv
// Two-channel scheduler sharing one GOST 28147-89 CFB core between independent streams.
// Keeps each channel's gamma context and reloads the core only when ownership or IV changes.
module gost89_cfb_ctx_sched #(
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   iv_wr,
  input  logic [63:0]  iv_data,
  input  logic [1:0]   s_valid,
  output logic [1:0]   s_ready,
  input  logic [127:0] s_data,
  output logic [1:0]   m_valid,
  input  logic [1:0]   m_ready,
  output logic [63:0]  m_data,
  output logic         core_reset,
  output logic         core_load,
  output logic [63:0]  core_in,
  input  logic [63:0]  core_out,
  input  logic         core_busy,
  output logic         sched_busy,
  output logic         cur_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELOAD,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_OUT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_ctx [2];
  logic [63:0] r_data;
  logic [63:0] r_core_in;
  logic [63:0] r_m_data;
  logic        r_cur_ch;
  logic        r_last_ch;
  logic        r_rr_ptr;
  logic        r_core_sync;
  logic        r_supp;

  logic        w_grant_any;
  logic        w_grant;
  logic        w_capture;
  logic        w_ack;
  logic        w_in_flight;
  logic        w_last_ch_next;

  always_comb begin
    w_grant_any = |s_valid;
    w_grant     = (s_valid == 2'b11) ? r_rr_ptr : s_valid[1];
    w_next      = r_state;
    s_ready     = 2'b00;
    m_valid     = 2'b00;
    core_reset  = 1'b0;
    core_load   = 1'b0;
    core_in     = r_core_in;
    w_capture   = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) begin
          s_ready[w_grant] = 1'b1;
          w_next = (r_core_sync && (r_last_ch == w_grant)) ? S_LOAD : S_RELOAD;
        end
      end
      S_RELOAD: begin
        core_reset = 1'b1;
        core_in    = r_ctx[r_cur_ch];
        w_next     = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        core_in   = r_data;
        w_next    = S_SETTLE;
      end
      // The core may not raise busy until a cycle after load_data, so skip one sample.
      S_SETTLE: w_next = S_RUN;
      S_RUN: begin
        if (!core_busy) begin
          w_capture = 1'b1;
          w_next    = S_OUT;
        end
      end
      S_OUT: begin
        m_valid[r_cur_ch] = 1'b1;
        if (m_ready[r_cur_ch]) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_in_flight    = (r_state == S_LOAD) || (r_state == S_SETTLE) || (r_state == S_RUN);
  assign w_last_ch_next = (r_state == S_LOAD) ? r_cur_ch : r_last_ch;

  // IV writes are applied last so they override both the chain update and the LOAD-time sync.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_ctx[0]    <= '0;
      r_ctx[1]    <= '0;
      r_data      <= '0;
      r_core_in   <= '0;
      r_m_data    <= '0;
      r_cur_ch    <= 1'b0;
      r_last_ch   <= 1'b0;
      r_rr_ptr    <= 1'b0;
      r_core_sync <= 1'b0;
      r_supp      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_core_in <= core_in;
      if ((r_state == S_IDLE) && w_grant_any) begin
        r_data   <= w_grant ? s_data[127:64] : s_data[63:0];
        r_cur_ch <= w_grant;
        r_rr_ptr <= ~w_grant;
      end
      if (r_state == S_LOAD) begin
        r_core_sync <= 1'b1;
        r_last_ch   <= r_cur_ch;
      end
      if (w_capture) begin
        r_m_data <= core_out;
        if (!r_supp) begin
          r_ctx[r_cur_ch] <= (MODE == 0) ? core_out : r_data;
        end
      end
      if (w_ack) begin
        r_supp <= 1'b0;
      end
      if (iv_wr[0]) begin
        r_ctx[0] <= iv_data;
      end
      if (iv_wr[1]) begin
        r_ctx[1] <= iv_data;
      end
      if (iv_wr[w_last_ch_next]) begin
        r_core_sync <= 1'b0;
      end
      if (iv_wr[r_cur_ch] && w_in_flight) begin
        r_supp <= 1'b1;
      end
    end
  end

  assign m_data     = r_m_data;
  assign sched_busy = (r_state != S_IDLE);
  assign cur_ch     = r_cur_ch;

endmodule

// File: tb/tb_gost89_cfb_ctx_sched.sv
// Directed bench for gost89_cfb_ctx_sched: an encrypt-mode and a decrypt-mode instance run
// side by side, each driving a behavioural CFB core whose keystream comes from known vectors.
module tb_gost89_cfb_ctx_sched;

  localparam logic [63:0] IV_A = 64'h6aa0379517bb57af;
  localparam logic [63:0] IV_B = 64'hfa5679a45f118aed;
  localparam logic [63:0] P1   = 64'h8d437364581af0da;
  localparam logic [63:0] C1   = 64'h54826055ab718bc7;
  localparam logic [63:0] P2   = 64'h12911df3eddcc0fb;
  localparam logic [63:0] C2   = 64'h585ddacf1a45e472;
  localparam logic [63:0] P3   = 64'h419677a6eff07f2f;
  localparam logic [63:0] C3   = 64'h27d3e781cc4fcf43;

  typedef struct {
    logic        wr0;
    logic [63:0] iv0;
    logic        wr1;
    logic [63:0] iv1;
    logic        ch;
    logic [63:0] din;
    logic [63:0] exp0;
    logic [63:0] exp1;
    logic [1:0]  mask;
    logic        expReload;
    logic [63:0] reloadIn;
    int          busyLen;
    int          midIvCyc;
    logic [63:0] midIv;
    logic        glitch;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   iv_wr = 2'b00;
  logic [63:0]  iv_data = '0;
  logic [1:0]   s_valid = 2'b00;
  logic [127:0] s_data = '0;
  logic [1:0]   m_ready = 2'b00;

  logic [1:0]   s_ready [2];
  logic [1:0]   m_valid [2];
  logic [63:0]  m_data [2];
  logic         core_reset [2];
  logic         core_load [2];
  logic [63:0]  core_in [2];
  logic [63:0]  core_out [2] = '{default: '0};
  logic         core_busy [2] = '{default: 1'b0};
  logic         sched_busy [2];
  logic         cur_ch [2];

  logic [63:0]  gammaR [2] = '{default: '0};
  logic [63:0]  inBuf [2] = '{default: '0};
  int           cnt [2] = '{default: 0};
  int           busyLen = 4;

  int compared = 0;
  int mismatched = 0;
  int overlapCnt = 0;

  always #5 clk = ~clk;

  gost89_cfb_ctx_sched #(.MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .iv_wr(iv_wr), .iv_data(iv_data),
    .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
    .m_valid(m_valid[0]), .m_ready(m_ready), .m_data(m_data[0]),
    .core_reset(core_reset[0]), .core_load(core_load[0]), .core_in(core_in[0]),
    .core_out(core_out[0]), .core_busy(core_busy[0]),
    .sched_busy(sched_busy[0]), .cur_ch(cur_ch[0])
  );

  gost89_cfb_ctx_sched #(.MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .iv_wr(iv_wr), .iv_data(iv_data),
    .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
    .m_valid(m_valid[1]), .m_ready(m_ready), .m_data(m_data[1]),
    .core_reset(core_reset[1]), .core_load(core_load[1]), .core_in(core_in[1]),
    .core_out(core_out[1]), .core_busy(core_busy[1]),
    .sched_busy(sched_busy[1]), .cur_ch(cur_ch[1])
  );

  // Keystream E(gamma) recovered from the known plaintext/ciphertext pairs.
  function automatic logic [63:0] keystream(input logic [63:0] g);
    case (g)
      IV_A:    return P1 ^ C1;
      C1:      return P2 ^ C2;
      IV_B:    return P3 ^ C3;
      default: return g ^ 64'h0f1e2d3c4b5a6978;
    endcase
  endfunction

  // Core k=0 chains on its output (encrypt), core k=1 chains on its input (decrypt).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (core_reset[k]) begin
        gammaR[k] <= core_in[k];
      end else if (core_load[k]) begin
        inBuf[k]     <= core_in[k];
        cnt[k]       <= busyLen;
        core_busy[k] <= 1'b1;
      end else if (core_busy[k]) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          core_busy[k] <= 1'b0;
          core_out[k]  <= inBuf[k] ^ keystream(gammaR[k]);
          gammaR[k]    <= (k == 0) ? (inBuf[k] ^ keystream(gammaR[k])) : inBuf[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (core_reset[k] && core_load[k]) overlapCnt++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s dut%0d s_ready", tag, k), 64'(s_ready[k]), 0);
      checkOutput($sformatf("%s dut%0d m_valid", tag, k), 64'(m_valid[k]), 0);
      checkOutput($sformatf("%s dut%0d m_data", tag, k), m_data[k], 0);
      checkOutput($sformatf("%s dut%0d core_in", tag, k), core_in[k], 0);
      checkOutput($sformatf("%s dut%0d core_reset", tag, k), 64'(core_reset[k]), 0);
      checkOutput($sformatf("%s dut%0d core_load", tag, k), 64'(core_load[k]), 0);
      checkOutput($sformatf("%s dut%0d sched_busy", tag, k), 64'(sched_busy[k]), 0);
      checkOutput($sformatf("%s dut%0d cur_ch", tag, k), 64'(cur_ch[k]), 0);
    end
  endtask

  task automatic writeIv(input int ch, input logic [63:0] d);
    iv_wr[ch] = 1'b1;
    iv_data   = d;
    @(posedge clk);
    #1;
    iv_wr = 2'b00;
  endtask

  // Holds s_valid[ch] until the grant is seen at a negedge; returns right after the handshake edge.
  task automatic waitGrant(input logic ch, input string tag);
    bit granted = 0;
    int waited = 0;
    s_valid[ch] = 1'b1;
    while (!granted && waited < 50) begin
      @(negedge clk);
      if (s_ready[0][ch] === 1'b1) granted = 1;
      else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    checkOutput({tag, " grant"}, 64'(granted), 1);
    @(posedge clk);
    #1;
    s_valid = 2'b00;
  endtask

  task automatic driveHooks(input vec_t v, input int lat);
    if (v.midIvCyc != 0) begin
      iv_wr[0] = (lat == v.midIvCyc);
      if (lat == v.midIvCyc) iv_data = v.midIv;
    end
    if (v.glitch) s_valid[~v.ch] = (lat == 2);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    bit seen = 0;
    bit sawReload = 0;
    logic [63:0] rl0 = '0;
    logic [63:0] rl1 = '0;
    logic [63:0] ld = '0;
    int idleHits = 0;
    busyLen = v.busyLen;
    if (v.wr0) writeIv(0, v.iv0);
    if (v.wr1) writeIv(1, v.iv1);
    s_data = v.ch ? {v.din, 64'h0} : {64'h0, v.din};
    waitGrant(v.ch, tag);
    lat = 1;
    driveHooks(v, lat);
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (core_reset[0]) begin
        sawReload = 1;
        rl0 = core_in[0];
        rl1 = core_in[1];
      end
      if (core_load[0]) ld = core_in[0];
      if (m_valid[0] != 2'b00) seen = 1;
      else begin
        @(posedge clk);
        #1;
        lat++;
        driveHooks(v, lat);
      end
    end
    iv_wr = 2'b00;
    s_valid = 2'b00;
    checkOutput({tag, " latency"}, 64'(lat), 64'(v.busyLen + 3 + int'(v.expReload)));
    checkOutput({tag, " reload seen"}, 64'(sawReload), 64'(v.expReload));
    checkOutput({tag, " load core_in"}, ld, v.din);
    if (v.mask[0]) begin
      checkOutput({tag, " dut0 m_data"}, m_data[0], v.exp0);
      checkOutput({tag, " dut0 m_valid"}, 64'(m_valid[0]), v.ch ? 2'b10 : 2'b01);
      if (v.expReload) checkOutput({tag, " dut0 reload core_in"}, rl0, v.reloadIn);
    end
    if (v.mask[1]) begin
      checkOutput({tag, " dut1 m_data"}, m_data[1], v.exp1);
      checkOutput({tag, " dut1 m_valid"}, 64'(m_valid[1]), v.ch ? 2'b10 : 2'b01);
      if (v.expReload) checkOutput({tag, " dut1 reload core_in"}, rl1, v.reloadIn);
    end
    m_ready[v.ch] = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 2'b00;
    @(negedge clk);
    checkOutput({tag, " m_valid cleared"}, 64'(m_valid[0]), 0);
    checkOutput({tag, " back to idle"}, 64'(sched_busy[0]), 0);
    if (v.glitch) begin
      for (int i = 0; i < 5; i++) begin
        if (sched_busy[0] || (s_ready[0] != 2'b00)) idleHits++;
        @(negedge clk);
      end
      checkOutput({tag, " withdrawn request ignored"}, 64'(idleHits), 0);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic wr0, input logic [63:0] iv0, input logic wr1,
                                 input logic [63:0] iv1, input logic ch, input logic [63:0] din,
                                 input logic [63:0] exp0, input logic [63:0] exp1,
                                 input logic [1:0] mask, input logic expReload,
                                 input logic [63:0] reloadIn, input int bl, input int midIvCyc,
                                 input logic [63:0] midIv, input logic glitch);
    vec_t v;
    v.wr0 = wr0; v.iv0 = iv0; v.wr1 = wr1; v.iv1 = iv1; v.ch = ch; v.din = din;
    v.exp0 = exp0; v.exp1 = exp1; v.mask = mask; v.expReload = expReload;
    v.reloadIn = reloadIn; v.busyLen = bl; v.midIvCyc = midIvCyc; v.midIv = midIv;
    v.glitch = glitch;
    return v;
  endfunction

  initial begin
    vec_t vecs [9];
    int grants;
    int cycles;
    int mv;
    logic [1:0] prevReady;
    logic [1:0] prevValid;

    vecs[0] = mkVec(1, IV_A, 0, 0,    0, P1, C1, C1, 2'b11, 1, IV_A, 4, 0, 0,    0);
    vecs[1] = mkVec(0, 0,    0, 0,    0, P2, C2, 0,  2'b01, 0, 0,    1, 0, 0,    0);
    vecs[2] = mkVec(1, IV_A, 1, IV_B, 0, P1, C1, C1, 2'b11, 1, IV_A, 4, 0, 0,    0);
    vecs[3] = mkVec(0, 0,    0, 0,    1, P3, C3, C3, 2'b11, 1, IV_B, 3, 0, 0,    0);
    vecs[4] = mkVec(0, 0,    0, 0,    0, P2, C2, 0,  2'b01, 1, C1,   2, 0, 0,    0);
    vecs[5] = mkVec(1, IV_A, 0, 0,    0, C1, P1, P1, 2'b11, 1, IV_A, 4, 0, 0,    0);
    vecs[6] = mkVec(0, 0,    0, 0,    0, C2, 0,  P2, 2'b10, 0, 0,    4, 0, 0,    1);
    vecs[7] = mkVec(1, IV_A, 0, 0,    0, P1, C1, C1, 2'b11, 1, IV_A, 4, 4, IV_B, 0);
    vecs[8] = mkVec(0, 0,    0, 0,    0, P3, C3, C3, 2'b11, 1, IV_B, 4, 0, 0,    0);

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset pulled mid-RUN must clear everything at once; a fresh IV then reproduces block one.
    writeIv(0, IV_A);
    busyLen = 4;
    s_data = {64'h0, P1};
    waitGrant(1'b0, "rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst pre-reset busy", 64'(sched_busy[0]), 1);
    checkOutput("rst pre-reset m_data", m_data[0], C3);
    reset_n = 1'b0;
    #1;
    checkResetState("midrun reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(vecs[0], "after reset");

    // Both channels requesting continuously with m_ready held high.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    busyLen = 2;
    m_ready = 2'b11;
    s_data = {P3, P1};
    s_valid = 2'b11;
    grants = 0;
    cycles = 0;
    mv = 0;
    prevReady = 2'b00;
    prevValid = 2'b00;
    while ((grants < 4 || sched_busy[0]) && cycles < 300) begin
      @(negedge clk);
      if (prevReady != 2'b00) checkOutput("rr s_ready one cycle", 64'(s_ready[0]), 0);
      if (prevValid != 2'b00) checkOutput("rr m_valid one cycle", 64'(m_valid[0]), 0);
      if (s_ready[0] != 2'b00) begin
        checkOutput($sformatf("rr grant %0d", grants), 64'(s_ready[0]), grants[0] ? 2'b10 : 2'b01);
        grants++;
      end
      if (m_valid[0] != 2'b00) mv++;
      prevReady = s_ready[0];
      prevValid = m_valid[0];
      @(posedge clk);
      #1;
      cycles++;
      if (grants >= 4) s_valid = 2'b00;
    end
    s_valid = 2'b00;
    m_ready = 2'b00;
    checkOutput("rr grant count", 64'(grants), 4);
    checkOutput("rr result count", 64'(mv), 4);
    checkOutput("core_reset/core_load overlap", 64'(overlapCnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
